// File: rtl/fft_bitrev_reorder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Output reorder stage for a radix-2 FFT. Samples arrive in bit-reversed order
// and are written into one of two N-entry banks at address bitrev(arrival
// index). Once a bank is full it is read out linearly, so consumers see bin 0,
// 1, ..., N-1. While one bank is read, the other bank is filled. Back-to-back
// frames therefore stream out with no gaps.
//
// Ports
//   clock   : sole clock, rising edge
//   reset   : synchronous, active-high
//   di_en   : input sample valid
//   di_re   : input real part   (bit-reversed order)
//   di_im   : input imag part
//   do_en   : output sample valid
//   do_re   : output real part  (natural order)
//   do_im   : output imag part
//   do_idx  : natural bin index of the current output
//             (present only when FFT_REORDER_IDX_EN is defined)
//
// Build option
//   FFT_REORDER_IDX_EN : adds the do_idx output port and its register.
// ----------------------------------------------------------------------------
module fft_bitrev_reorder #(
    parameter int N     = 512,
    parameter int WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   di_en,
    input  logic [WIDTH-1:0]       di_re,
    input  logic [WIDTH-1:0]       di_im,
    output logic                   do_en,
    output logic [WIDTH-1:0]       do_re,
    output logic [WIDTH-1:0]       do_im
`ifdef FFT_REORDER_IDX_EN
    ,
    output logic [$clog2(N)-1:0]   do_idx
`endif
);

    localparam int NN = $clog2(N);
    localparam int AW = NN + 1;   // bank select bit + in-bank address
    localparam int DW = 2 * WIDTH;

    localparam logic [NN-1:0] CNT_ONE  = NN'(1);
    localparam logic [NN-1:0] CNT_LAST = NN'(N - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Reverse the NN address bits of the arrival counter.
    function automatic logic [NN-1:0] bitrev(input logic [NN-1:0] a);
        logic [NN-1:0] r;
        r = '0;
        for (int i = 0; i < NN; i++) begin
            r[i] = a[NN-1-i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Storage: both banks live in one simple dual-port array. The top
    // address bit selects the bank.
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [0:2*N-1];

    // Per-bank status, one bit per bank.
    logic [1:0] bank_full;
    logic [1:0] bank_reading;

    // ------------------------------------------------------------------
    // Writer
    // ------------------------------------------------------------------
    logic          wr_bank_reg;
    logic [NN-1:0] wr_cnt_reg;
    logic          wr_fire;
    logic          wr_last;
    logic [AW-1:0] wr_addr;

    // A READING bank is never the write target in legal operation. The guard
    // only keeps a frame being read out intact if that ever changed.
    assign wr_fire = di_en && !reset && !bank_reading[wr_bank_reg];
    assign wr_last = wr_fire && (wr_cnt_reg == CNT_LAST);
    assign wr_addr = {wr_bank_reg, bitrev(wr_cnt_reg)};

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_bank_reg <= 1'b0;
            wr_cnt_reg  <= '0;
        end else if (wr_fire) begin
            // The counter wraps from N-1 to 0 on its own because N is a power of two.
            wr_cnt_reg <= wr_cnt_reg + CNT_ONE;
            if (wr_last) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[wr_addr] <= {di_re, di_im};
        end
    end

    // ------------------------------------------------------------------
    // Reader FSM: state register / next-state logic / output decode
    // ------------------------------------------------------------------
    rd_state_t     rd_state_reg, rd_state_next;
    logic          rd_bank_reg,  rd_bank_next;
    logic [NN-1:0] rd_cnt_reg,   rd_cnt_next;

    logic          rd_start;       // IDLE -> READ this cycle
    logic          rd_start_bank;  // bank claimed by rd_start
    logic          rd_done;        // final read of rd_bank_reg this cycle
    logic          rd_switch;      // final read, with the other bank already FULL
    logic          rd_fire;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_reg <= RD_IDLE;
            rd_bank_reg  <= 1'b0;
            rd_cnt_reg   <= '0;
        end else begin
            rd_state_reg <= rd_state_next;
            rd_bank_reg  <= rd_bank_next;
            rd_cnt_reg   <= rd_cnt_next;
        end
    end

    // Bin 0 is read on the same edge that leaves IDLE. This gives the
    // one-cycle latency from the last input sample, so rd_cnt resumes at 1.
    always_comb begin
        rd_state_next = rd_state_reg;
        rd_bank_next  = rd_bank_reg;
        rd_cnt_next   = rd_cnt_reg;
        rd_start      = 1'b0;
        rd_start_bank = 1'b0;
        rd_done       = 1'b0;
        rd_switch     = 1'b0;
        case (rd_state_reg)
            RD_IDLE: begin
                if (|bank_full) begin
                    rd_start      = 1'b1;
                    rd_start_bank = bank_full[0] ? 1'b0 : 1'b1;
                    rd_state_next = RD_READ;
                    rd_bank_next  = rd_start_bank;
                    rd_cnt_next   = CNT_ONE;
                end
            end
            RD_READ: begin
                rd_cnt_next = rd_cnt_reg + CNT_ONE;
                if (rd_cnt_reg == CNT_LAST) begin
                    rd_done     = 1'b1;
                    rd_cnt_next = '0;
                    if (bank_full[~rd_bank_reg]) begin
                        rd_switch    = 1'b1;
                        rd_bank_next = ~rd_bank_reg;
                    end else begin
                        rd_state_next = RD_IDLE;
                    end
                end
            end
            default: begin
                rd_state_next = RD_IDLE;
                rd_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        rd_fire = rd_start || (rd_state_reg == RD_READ);
        rd_addr = rd_start ? {rd_start_bank, {NN{1'b0}}} : {rd_bank_reg, rd_cnt_reg};
    end

`ifdef FFT_REORDER_IDX_EN
    logic [NN-1:0] rd_idx;
    assign rd_idx = rd_start ? '0 : rd_cnt_reg;
`endif

    // ------------------------------------------------------------------
    // Bank status. The writer fills wr_bank_reg. The reader claims and
    // releases banks. They never touch the same bank on the same edge.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            bank_state_t state_reg, state_next;

            always_comb begin
                state_next = state_reg;
                if (wr_fire && (wr_bank_reg == 1'(gi))) begin
                    state_next = wr_last ? BANK_FULL : BANK_FILLING;
                end
                if ((rd_start && (rd_start_bank == 1'(gi))) ||
                    (rd_switch && (rd_bank_next == 1'(gi)))) begin
                    state_next = BANK_READING;
                end
                if (rd_done && (rd_bank_reg == 1'(gi))) begin
                    state_next = BANK_EMPTY;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    state_reg <= BANK_EMPTY;
                end else begin
                    state_reg <= state_next;
                end
            end

            assign bank_full[gi]    = (state_reg == BANK_FULL);
            assign bank_reading[gi] = (state_reg == BANK_READING);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register. This is the registered read port of the RAM. Data
    // holds whenever do_en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            do_en <= 1'b0;
            do_re <= '0;
            do_im <= '0;
        end else begin
            do_en <= rd_fire;
            if (rd_fire) begin
                {do_re, do_im} <= mem[rd_addr];
            end
        end
    end

`ifdef FFT_REORDER_IDX_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            do_idx <= '0;
        end else if (rd_fire) begin
            do_idx <= rd_idx;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
`timescale 1ns/1ps
// Testbench for fft_bitrev_reorder (N=512, WIDTH=16).
// A frame-level model predicts the output stream. Each output bin k carries
// the sample that arrived at index bitrev(k). Output starts one cycle after
// the last sample of a frame, or right after the previous frame's output,
// whichever is later. A per-cycle compare checks the DUT against that
// prediction. A few literal expectations pin the model.
module tb_fft_bitrev_reorder;

    localparam int N     = 512;
    localparam int WIDTH = 16;
    localparam int NN    = 9;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             di_en = 1'b0;
    logic [WIDTH-1:0] di_re = '0;
    logic [WIDTH-1:0] di_im = '0;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
`ifdef FFT_REORDER_IDX_EN
    logic [NN-1:0]    do_idx;
`endif

    always #5 clock = ~clock;

    fft_bitrev_reorder #(.N(N), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
`ifdef FFT_REORDER_IDX_EN
        ,
        .do_idx(do_idx)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at edge %0d: actual=%h required=%h", name, edge_cnt, act, req);
        end
    endtask

    function automatic int rev(input int x);
        int r;
        r = 0;
        for (int i = 0; i < NN; i++) r = r * 2 + ((x >> i) & 1);
        return r;
    endfunction

    // ---------------- model ----------------
    typedef struct {
        int          cyc;
        logic [15:0] re;
        logic [15:0] im;
        int          idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] frame_re[N];
    logic [15:0] frame_im[N];
    int          fill      = 0;
    int          next_free = 0;
    int          edge_cnt  = 0;
    int          rst_edge  = -1;
    int          ovf_cnt   = 0;

    initial begin
        forever begin
            @(posedge clock);
            edge_cnt++;
            if (di_en && !reset && dut.bank_reading[dut.wr_bank_reg]) ovf_cnt++;
            if (reset) begin
                exp_q.delete();
                fill      = 0;
                next_free = 0;
                rst_edge  = edge_cnt;
            end else if (di_en) begin
                frame_re[fill] = di_re;
                frame_im[fill] = di_im;
                fill++;
                if (fill == N) begin
                    int start;
                    start = (edge_cnt + 1 > next_free) ? edge_cnt + 1 : next_free;
                    for (int k = 0; k < N; k++) begin
                        exp_t e;
                        e.cyc = start + k;
                        e.re  = frame_re[rev(k)];
                        e.im  = frame_im[rev(k)];
                        e.idx = k;
                        exp_q.push_back(e);
                    end
                    next_free = start + N;
                    fill      = 0;
                end
            end
        end
    end

    // ---------------- compare + run tracking ----------------
    logic [15:0] held_re = '0;
    logic [15:0] held_im = '0;
    int          run = 0, run_start = 0, last_run_len = 0, last_run_start = 0;
    bit          cap_on = 0;
    int          cap_n  = 0;
    logic [15:0] cap_re[N];
    logic [15:0] cap_im[N];

    initial begin
        forever begin
            @(negedge clock);
            if (edge_cnt == 0) continue;
            if (rst_edge == edge_cnt) begin
                chk("reset_en", {31'd0, do_en}, 32'd0);
                chk("reset_re", {16'd0, do_re}, 32'd0);
                chk("reset_im", {16'd0, do_im}, 32'd0);
                held_re = '0;
                held_im = '0;
            end else if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_en", {31'd0, do_en}, 32'd1);
                chk("out_re", {16'd0, do_re}, {16'd0, e.re});
                chk("out_im", {16'd0, do_im}, {16'd0, e.im});
`ifdef FFT_REORDER_IDX_EN
                chk("out_idx", {23'd0, do_idx}, 32'(e.idx));
`endif
                held_re = e.re;
                held_im = e.im;
            end else begin
                chk("idle_en", {31'd0, do_en}, 32'd0);
                chk("idle_hold", {do_re, do_im}, {held_re, held_im});
            end
            if (do_en === 1'b1) begin
                if (run == 0) run_start = edge_cnt;
                run++;
                if (cap_on && cap_n < N) begin
                    cap_re[cap_n] = do_re;
                    cap_im[cap_n] = do_im;
                    cap_n++;
                end
            end else if (run > 0) begin
                last_run_len   = run;
                last_run_start = run_start;
                run            = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int last_in_edge = 0;

    task automatic drive_frame(input int gap, input int base);
        for (int n = 0; n < N; n++) begin
            logic [15:0] v;
            v     = 16'(base + n);
            di_en = 1'b1;
            di_re = v;
            di_im = ~v;
            @(posedge clock); #1;
            last_in_edge = edge_cnt;
            if (gap > 0) begin
                di_en = 1'b0;
                repeat (gap) begin @(posedge clock); #1; end
            end
        end
        di_en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        reset = 1'b1;
        wait_cycles(3);
        chk("por_en", {31'd0, do_en}, 32'd0);
        chk("por_re", {16'd0, do_re}, 32'd0);
        reset = 1'b0;
        wait_cycles(2);

        // Single contiguous frame: re=n, im=~n
        cap_on = 1;
        drive_frame(0, 0);
        wait_cycles(N + 5);
        cap_on = 0;
        $display("frame1: last_in=%0d first_out=%0d len=%0d", last_in_edge, last_run_start, last_run_len);
        chk("latency", 32'(last_run_start), 32'(last_in_edge + 1));
        chk("frame1_len", 32'(last_run_len), 32'd512);
        chk("bin0_re", {16'd0, cap_re[0]}, 32'h0000);
        chk("bin1_re", {16'd0, cap_re[1]}, 32'h0100);
        chk("bin2_re", {16'd0, cap_re[2]}, 32'h0080);
        chk("bin511_re", {16'd0, cap_re[511]}, 32'h01FF);
        chk("bin1_im", {16'd0, cap_im[1]}, 32'hFEFF);
        chk("bin511_im", {16'd0, cap_im[511]}, 32'hFE00);

        // Three back-to-back frames
        drive_frame(0, 16'h1000);
        drive_frame(0, 16'h2000);
        drive_frame(0, 16'h3000);
        wait_cycles(N + 5);
        $display("3 frames: first_out=%0d len=%0d", last_run_start, last_run_len);
        chk("b2b_len", 32'(last_run_len), 32'd1536);

        // Gapped input, every other cycle
        drive_frame(1, 16'h4000);
        wait_cycles(N + 5);
        $display("gapped: last_in=%0d first_out=%0d len=%0d", last_in_edge, last_run_start, last_run_len);
        chk("gap_latency", 32'(last_run_start), 32'(last_in_edge + 1));
        chk("gap_len", 32'(last_run_len), 32'd512);

        // Reset after 200 samples, with di_en high on the reset edge
        for (int n = 0; n < 200; n++) begin
            di_en = 1'b1; di_re = 16'(16'h9000 + n); di_im = 16'(n);
            @(posedge clock); #1;
        end
        reset = 1'b1; di_en = 1'b1; di_re = 16'hDEAD; di_im = 16'hBEEF;
        @(posedge clock); #1;
        reset = 1'b0; di_en = 1'b0;
        chk("midfill_rst_en", {31'd0, do_en}, 32'd0);
        chk("midfill_rst_re", {16'd0, do_re}, 32'd0);
        drive_frame(0, 16'h5000);
        wait_cycles(N + 5);
        $display("after reset: len=%0d", last_run_len);
        chk("post_rst_len", 32'(last_run_len), 32'd512);

        // Reset during readout
        drive_frame(0, 16'h6000);
        for (int i = 0; i < N + 20; i++) begin
            @(negedge clock);
            if (run >= 100) break;
        end
        chk("reach_bin100", {31'd0, (run >= 100)}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("readout_rst_en", {31'd0, do_en}, 32'd0);
        wait_cycles(3);
        drive_frame(0, 16'h7000);
        wait_cycles(N + 5);
        $display("recovery: len=%0d", last_run_len);
        chk("recover_len", 32'(last_run_len), 32'd512);

        chk("overflow", 32'(ovf_cnt), 32'd0);
        chk("model_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
